average_filter_mc: RTL and testbench

AVERAGE_FILTER_MC -- requirements
Module: average_filter_mc

---
 rtl/average_filter_mc.sv | 137 +++++++++++++
 tb/tb_average_filter_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/average_filter_mc.sv
// ---------------------------------------------------------------------------
// average_filter_mc
// Multi-channel averaging filter. Each channel keeps its own running sum,
// a 2^K-deep tap history and a write pointer. A channel updates once per
// rising edge of its din_en strobe.
//
// mode 0 : boxcar moving average over the last 2^K samples.
// mode 1 : exponential average with weight 2^-K.
//
// The first sample after reset or clear "primes" the channel: the history
// is filled with that sample, so the output starts at the sample value
// rather than ramping up from zero.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst        : asynchronous active-low reset
//   din        : CH packed W-bit unsigned samples, channel c at [c*W +: W]
//   din_en     : per-channel sample strobe (rising edge = one new sample)
//   mode       : 0 = boxcar, 1 = exponential; a change clears all channels
//   clr        : synchronous clear of all channel histories
//   dout       : CH packed W-bit averaged outputs, registered
//   dout_valid : one-cycle pulse per channel update
//   primed     : channel has taken at least one sample since reset/clear
// ---------------------------------------------------------------------------
module average_filter_mc #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int K  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] din,
    input  logic [CH-1:0]   din_en,
    input  logic            mode,
    input  logic            clr,
    output logic [CH*W-1:0] dout,
    output logic [CH-1:0]   dout_valid,
    output logic [CH-1:0]   primed
);

    localparam int DEPTH = 1 << K;
    localparam int SW    = W + K;

    // Strobe synchronisation stages and the sample pipeline kept in step
    // with them, so the sample used is the one present when din_en was
    // first registered high.
    logic [CH-1:0]   r0, r1, r2;
    logic [CH*W-1:0] d0, d1;
    logic            mode_q;

    logic [SW-1:0]   sum_q [CH];
    logic [W-1:0]    tap_q [CH][DEPTH];
    logic [K-1:0]    ptr_q [CH];

    logic            clr_eff;
    logic [CH-1:0]   upd;
    logic [SW-1:0]   sum_nxt [CH];

    // The sum always equals a sum of 2^K W-bit values (boxcar) or stays
    // bounded by 2^K * max sample (exponential), so modular W+K arithmetic
    // yields the exact result even if the intermediate sum+x wraps.
    function automatic logic [SW-1:0] next_sum(
        input logic          is_primed,
        input logic          exp_mode,
        input logic [SW-1:0] sum,
        input logic [W-1:0]  x,
        input logic [W-1:0]  oldest
    );
        logic [SW-1:0] x_ext;
        logic [SW-1:0] sub;
        logic [SW-1:0] result;
        x_ext = {{K{1'b0}}, x};
        sub   = exp_mode ? (sum >> K) : {{K{1'b0}}, oldest};
        if (!is_primed)
            result = {x, {K{1'b0}}};
        else
            result = sum + x_ext - sub;
        return result;
    endfunction

    // A mode change is treated as a clear for that cycle.
    assign clr_eff = clr | (mode ^ mode_q);

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            upd[c]     = r1[c] & ~r2[c] & ~clr_eff;
            sum_nxt[c] = next_sum(primed[c], mode, sum_q[c],
                                  d1[c*W +: W], tap_q[c][ptr_q[c]]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0         <= '0;
            r1         <= '0;
            r2         <= '0;
            d0         <= '0;
            d1         <= '0;
            mode_q     <= 1'b0;
            dout       <= '0;
            dout_valid <= '0;
            primed     <= '0;
            for (int c = 0; c < CH; c++) begin
                sum_q[c] <= '0;
                ptr_q[c] <= '0;
                for (int j = 0; j < DEPTH; j++)
                    tap_q[c][j] <= '0;
            end
        end else begin
            r0         <= din_en;
            r1         <= r0;
            r2         <= r1;
            d0         <= din;
            d1         <= d0;
            mode_q     <= mode;
            dout_valid <= upd;
            for (int c = 0; c < CH; c++) begin
                if (clr_eff) begin
                    primed[c] <= 1'b0;
                end else if (upd[c]) begin
                    primed[c]         <= 1'b1;
                    sum_q[c]          <= sum_nxt[c];
                    dout[c*W +: W]    <= sum_nxt[c][SW-1:K];
                    if (!primed[c]) begin
                        ptr_q[c] <= '0;
                        for (int j = 0; j < DEPTH; j++)
                            tap_q[c][j] <= d1[c*W +: W];
                    end else if (!mode) begin
                        tap_q[c][ptr_q[c]] <= d1[c*W +: W];
                        ptr_q[c]           <= ptr_q[c] + K'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_average_filter_mc.sv
module tb_average_filter_mc;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int K  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] din;
    logic [CH-1:0]   din_en;
    logic            mode;
    logic            clr;
    logic [CH*W-1:0] dout;
    logic [CH-1:0]   dout_valid;
    logic [CH-1:0]   primed;

    always #5 clk = ~clk;

    average_filter_mc #(.CH(CH), .W(W), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .mode       (mode),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: window kept as a plain shift list of the last four
    // samples, exponential state as an integer sum.
    int m_win   [CH][4];
    int m_sum   [CH];
    int m_dout  [CH];
    bit m_primed[CH];
    bit m_mode;

    typedef struct {
        bit          mode;
        int          ch;
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < CH; c++) m_primed[c] = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_primed[c] = 1'b0;
            m_dout[c]   = 0;
            m_sum[c]    = 0;
        end
    endfunction

    function automatic void model_update(input int c, input int x);
        int s;
        s = 0;
        if (!m_primed[c]) begin
            for (int i = 0; i < 4; i++) m_win[c][i] = x;
            m_sum[c]    = x * 4;
            m_primed[c] = 1'b1;
            m_dout[c]   = x;
        end else if (!m_mode) begin
            for (int i = 0; i < 3; i++) m_win[c][i] = m_win[c][i+1];
            m_win[c][3] = x;
            for (int i = 0; i < 4; i++) s += m_win[c][i];
            m_dout[c] = s / 4;
        end else begin
            m_sum[c]  = m_sum[c] + x - m_sum[c] / 4;
            m_dout[c] = m_sum[c] / 4;
        end
    endfunction

    function automatic logic [3:0] model_primed_vec();
        logic [3:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_primed[c];
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s dout%0d", tag, c), 64'(dout[c*W +: W]), 64'(m_dout[c]));
        check($sformatf("%s primed", tag), 64'(primed), 64'(model_primed_vec()));
    endtask

    // One strobe on the channels in mask; din is scrambled after the first
    // registering edge so a wrong capture point shows up.
    task automatic pulse(input logic [3:0] mask, input logic [63:0] vals, input string tag);
        @(negedge clk);
        din    = vals;
        din_en = mask;
        @(negedge clk);
        din_en = '0;
        din    = {$urandom, $urandom};
        check($sformatf("%s valid_early1", tag), 64'(dout_valid), 64'(0));
        @(negedge clk);
        check($sformatf("%s valid_early2", tag), 64'(dout_valid), 64'(0));
        for (int c = 0; c < CH; c++)
            if (mask[c]) model_update(c, int'(vals[c*W +: W]));
        @(negedge clk);
        check($sformatf("%s valid", tag), 64'(dout_valid), 64'(mask));
        check_outputs(tag);
        @(negedge clk);
        check($sformatf("%s valid_after", tag), 64'(dout_valid), 64'(0));
    endtask

    task automatic set_mode(input bit m);
        @(negedge clk);
        mode   = m;
        m_mode = m;
        model_clear();
        @(negedge clk);
        check("mode_change primed", 64'(primed), 64'(0));
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check("clear primed", 64'(primed), 64'(0));
        check("clear valid", 64'(dout_valid), 64'(0));
    endtask

    task automatic add(input bit m, input int ch, input logic [15:0] x, input logic [15:0] e);
        vec_t v;
        v.mode = m; v.ch = ch; v.x = x; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] vals;
        int          cnt;
        logic [15:0] v;

        // Directed vectors: boxcar, exponential, full scale both modes.
        add(0, 0, 16'd100, 16'd100);
        add(0, 0, 16'd200, 16'd125);
        add(0, 0, 16'd200, 16'd150);
        add(0, 0, 16'd200, 16'd175);
        add(0, 0, 16'd200, 16'd200);
        add(1, 1, 16'd100, 16'd100);
        add(1, 1, 16'd200, 16'd125);
        add(1, 1, 16'd200, 16'd143);
        for (int i = 0; i < 6; i++) add(0, 2, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 6; i++) add(1, 2, 16'hFFFF, 16'hFFFF);

        // Reset with din_en[3] already high: first sample after release primes.
        rst    = 1'b0;
        clr    = 1'b0;
        mode   = 1'b0;
        m_mode = 1'b0;
        din    = '0;
        din[48 +: 16] = 16'd33;
        din_en = 4'b1000;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset dout", 64'(dout), 64'(0));
        check("reset valid", 64'(dout_valid), 64'(0));
        check("reset primed", 64'(primed), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("held_in_reset valid1", 64'(dout_valid), 64'(0));
        @(negedge clk);
        check("held_in_reset valid2", 64'(dout_valid), 64'(0));
        model_update(3, 33);
        @(negedge clk);
        check("held_in_reset valid", 64'(dout_valid), 64'(4'b1000));
        check_outputs("held_in_reset");
        din_en = '0;
        repeat (3) @(negedge clk);
        check("held_in_reset single", 64'(dout_valid), 64'(0));

        // Table-driven directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].mode != m_mode) set_mode(tbl[i].mode);
            vals = '0;
            vals[tbl[i].ch*W +: W] = tbl[i].x;
            pulse(4'(1 << tbl[i].ch), vals, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), 64'(dout[tbl[i].ch*W +: W]), 64'(tbl[i].exp));
        end

        // Clear coincident with a ch2 update.
        set_mode(0);
        vals = '0; vals[32 +: 16] = 16'd100;
        pulse(4'b0100, vals, "clr_hist");
        @(negedge clk);
        din[32 +: 16] = 16'd50;
        din_en = 4'b0100;
        @(negedge clk);
        din_en = '0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check("clr_drop valid", 64'(dout_valid), 64'(0));
        check("clr_drop dout2", 64'(dout[32 +: 16]), 64'(100));
        check("clr_drop primed", 64'(primed), 64'(0));
        @(negedge clk);
        check("clr_drop valid_late", 64'(dout_valid), 64'(0));
        vals = '0; vals[32 +: 16] = 16'd60;
        pulse(4'b0100, vals, "clr_next");
        check("clr_next dout2", 64'(dout[32 +: 16]), 64'(60));

        // din_en0 held high for 10 cycles -> exactly one update.
        v = 16'($urandom);
        @(negedge clk);
        din[0 +: 16] = v;
        din_en = 4'b0001;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (dout_valid[0]) cnt++;
        end
        din_en = '0;
        repeat (3) begin
            @(negedge clk);
            if (dout_valid[0]) cnt++;
        end
        model_update(0, int'(v));
        check("held_high pulses", 64'(cnt), 64'(1));
        check_outputs("held_high");

        // ch0 and ch3 on the same cycle.
        vals = {$urandom, $urandom};
        pulse(4'b1001, vals, "simul03");

        // Randomized traffic in both modes, with occasional clears.
        for (int i = 0; i < 40; i++) begin
            if (i % 9 == 4) do_clear();
            pulse(4'($urandom_range(1, 15)), {$urandom, $urandom}, $sformatf("rnd0_%0d", i));
        end
        set_mode(1);
        for (int i = 0; i < 40; i++) begin
            if (i % 9 == 4) do_clear();
            pulse(4'($urandom_range(1, 15)), {$urandom, $urandom}, $sformatf("rnd1_%0d", i));
        end
        set_mode(0);
        pulse(4'b1111, {$urandom, $urandom}, "prime_all");

        // Reset in the middle of an update pipeline.
        @(negedge clk);
        din[16 +: 16] = 16'd55;
        din_en = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_mid dout", 64'(dout), 64'(0));
        check("rst_mid valid", 64'(dout_valid), 64'(0));
        check("rst_mid primed", 64'(primed), 64'(0));
        @(negedge clk);
        rst    = 1'b1;
        din_en = '0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (dout_valid != '0) cnt++;
        end
        check("rst_mid no_pulse", 64'(cnt), 64'(0));
        vals = '0; vals[16 +: 16] = 16'd77;
        pulse(4'b0010, vals, "rst_next");
        check("rst_next dout1", 64'(dout[16 +: 16]), 64'(77));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
